// File: rtl/led_dimmer.sv
// Multi-channel LED dimmer: shared PWM counter, per-channel double-buffered duty
// and an activity pulse stretcher, all on a single clock.
module led_dimmer #(
    parameter int CHANNELS      = 8,
    parameter int PWM_BITS      = 3,
    parameter int PRESCALE      = 1,
    parameter int STRETCH_TICKS = 0,
    parameter int DEFAULT_DUTY  = 1
) (
    input  logic                clock,
    input  logic                res,
    input  logic [CHANNELS-1:0] led_in,
    input  logic                duty_we,
    input  logic [4:0]          duty_sel,
    input  logic [PWM_BITS:0]   duty_data,
    output logic [CHANNELS-1:0] led_out,
    output logic                frame
);

    localparam int DW = PWM_BITS + 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (STRETCH_TICKS > 0) ? $clog2(STRETCH_TICKS + 1) : 1;

    localparam logic [DW-1:0]       DUTY_FULL    = DW'(2 ** PWM_BITS);
    localparam logic [DW-1:0]       DUTY_RST     = DW'(DEFAULT_DUTY);
    localparam logic [PW-1:0]       PRESC_LAST   = PW'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST     = '1;
    localparam logic [SW-1:0]       STRETCH_LOAD = SW'(STRETCH_TICKS);

    function automatic logic [DW-1:0] sat_duty(input logic [DW-1:0] d);
        return (d > DUTY_FULL) ? DUTY_FULL : d;
    endfunction

    logic [PW-1:0]       presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DW-1:0]       duty_cur_q    [CHANNELS];
    logic [DW-1:0]       duty_cur_d    [CHANNELS];
    logic [DW-1:0]       duty_shadow_q [CHANNELS];
    logic [DW-1:0]       duty_shadow_d [CHANNELS];
    logic [SW-1:0]       stretch_q     [CHANNELS];
    logic [SW-1:0]       stretch_d     [CHANNELS];
    logic [CHANNELS-1:0] led_out_q, led_out_d;
    logic                frame_q, frame_d;

    logic                tick;
    logic                boundary;
    logic [CHANNELS-1:0] active;

    always_comb begin
        tick          = (presc_q == PRESC_LAST);
        boundary      = tick && (pwm_cnt_q == CNT_LAST);
        presc_d       = tick ? '0 : presc_q + 1'b1;
        pwm_cnt_d     = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        frame_d       = boundary;
        duty_cur_d    = duty_cur_q;
        duty_shadow_d = duty_shadow_q;
        stretch_d     = stretch_q;
        active        = '0;
        led_out_d     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            // Current duty latches the shadow as it stood before any same-edge write.
            if (boundary) begin
                duty_cur_d[i] = duty_shadow_q[i];
            end
            if (duty_we && (duty_sel == 5'(i))) begin
                duty_shadow_d[i] = sat_duty(duty_data);
            end
            if (led_in[i]) begin
                stretch_d[i] = STRETCH_LOAD;
            end else if (tick && (stretch_q[i] != '0)) begin
                stretch_d[i] = stretch_q[i] - 1'b1;
            end
            active[i]    = led_in[i] | (stretch_q[i] != '0);
            led_out_d[i] = active[i] & ({1'b0, pwm_cnt_q} < duty_cur_q[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (res) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            led_out_q <= '0;
            frame_q   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_cur_q[i]    <= DUTY_RST;
                duty_shadow_q[i] <= DUTY_RST;
                stretch_q[i]     <= '0;
            end
        end else begin
            presc_q       <= presc_d;
            pwm_cnt_q     <= pwm_cnt_d;
            led_out_q     <= led_out_d;
            frame_q       <= frame_d;
            duty_cur_q    <= duty_cur_d;
            duty_shadow_q <= duty_shadow_d;
            stretch_q     <= stretch_d;
        end
    end

    assign led_out = led_out_q;
    assign frame   = frame_q;

endmodule
